wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 39 +++
 rtl/wb_skid_fifo.sv | 56 +++++
 rtl/wb_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions for the writeback arbiter: widths, limits, source
// encodings and the per-requester wait-counter update.
package wb_arbiter_pkg;

  localparam int SCOREBOARD_SIZE_WIDTH = 4;
  localparam int WB_STARVE_LIMIT       = 4;
  localparam int ALU_WB_FIFO_DEPTH     = 2;
  localparam int WB_WAIT_W             = 3;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MUL = 2'd1,
    WB_SRC_LSU = 2'd2
  } wb_src_e;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_FIFO,
    GNT_ALU,
    GNT_MUL,
    GNT_LSU
  } grant_e;

  typedef struct packed {
    logic [SCOREBOARD_SIZE_WIDTH-1:0] sid;
    logic [4:0]                       rd;
    logic [63:0]                      value;
  } wb_payload_t;

  // Wait counter saturates at the starvation limit and clears on grant or idle.
  function automatic logic [WB_WAIT_W-1:0] next_wait(input logic valid,
                                                     input logic granted,
                                                     input logic [WB_WAIT_W-1:0] cur);
    if (!valid || granted) return '0;
    if (cur == WB_WAIT_W'(WB_STARVE_LIMIT)) return cur;
    return cur + WB_WAIT_W'(1);
  endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Small circular FIFO that parks ALU results the writeback port could not
// take in their arrival cycle.
module wb_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage has no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= inc_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU, MUL and LSU results onto one registered
// writeback port with starvation protection and an ALU skid FIFO.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             alu_valid_i,
  input  logic [SCOREBOARD_SIZE_WIDTH-1:0] alu_sid_i,
  input  logic [4:0]                       alu_rd_i,
  input  logic [63:0]                      alu_value_i,
  output logic                             alu_stall_o,
  input  logic                             mul_valid_i,
  input  logic [SCOREBOARD_SIZE_WIDTH-1:0] mul_sid_i,
  input  logic [4:0]                       mul_rd_i,
  input  logic [63:0]                      mul_value_i,
  output logic                             mul_ready_o,
  input  logic                             lsu_valid_i,
  input  logic [SCOREBOARD_SIZE_WIDTH-1:0] lsu_sid_i,
  input  logic [4:0]                       lsu_rd_i,
  input  logic [63:0]                      lsu_value_i,
  output logic                             lsu_ready_o,
  output logic                             wb_valid_o,
  output logic [SCOREBOARD_SIZE_WIDTH-1:0] wb_sid_o,
  output logic [4:0]                       wb_rd_o,
  output logic [63:0]                      wb_value_o,
  output logic [1:0]                       wb_src_o
);

  localparam int CNT_W = $clog2(ALU_WB_FIFO_DEPTH + 1);

  wb_payload_t          alu_in;
  wb_payload_t          mul_in;
  wb_payload_t          lsu_in;
  wb_payload_t          fifo_head;
  wb_payload_t          sel;
  wb_src_e              sel_src;
  grant_e               grant;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [WB_WAIT_W-1:0] mul_wait;
  logic [WB_WAIT_W-1:0] lsu_wait;
  logic                 mul_starved;
  logic                 lsu_starved;
  logic                 rr;
  logic                 run;

  assign alu_in = '{sid: alu_sid_i, rd: alu_rd_i, value: alu_value_i};
  assign mul_in = '{sid: mul_sid_i, rd: mul_rd_i, value: mul_value_i};
  assign lsu_in = '{sid: lsu_sid_i, rd: lsu_rd_i, value: lsu_value_i};

  assign mul_starved = mul_valid_i && (mul_wait == WB_WAIT_W'(WB_STARVE_LIMIT));
  assign lsu_starved = lsu_valid_i && (lsu_wait == WB_WAIT_W'(WB_STARVE_LIMIT));

  // run holds off grants for the first cycle after reset release.
  always_comb begin
    grant = GNT_NONE;
    if (!run)                             grant = GNT_NONE;
    else if (mul_starved && lsu_starved)  grant = rr ? GNT_LSU : GNT_MUL;
    else if (mul_starved)                 grant = GNT_MUL;
    else if (lsu_starved)                 grant = GNT_LSU;
    else if (!fifo_empty)                 grant = GNT_FIFO;
    else if (alu_valid_i)                 grant = GNT_ALU;
    else if (mul_valid_i && lsu_valid_i)  grant = rr ? GNT_LSU : GNT_MUL;
    else if (mul_valid_i)                 grant = GNT_MUL;
    else if (lsu_valid_i)                 grant = GNT_LSU;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    sel     = '0;
    sel_src = WB_SRC_ALU;
    case (grant)
      GNT_FIFO: sel = fifo_head;
      GNT_ALU:  sel = alu_in;
      GNT_MUL:  begin sel = mul_in; sel_src = WB_SRC_MUL; end
      GNT_LSU:  begin sel = lsu_in; sel_src = WB_SRC_LSU; end
      default:  ;
    endcase
  end

  assign mul_ready_o = (grant == GNT_MUL);
  assign lsu_ready_o = (grant == GNT_LSU);
  assign fifo_push   = alu_valid_i && (grant != GNT_ALU);
  assign fifo_pop    = (grant == GNT_FIFO);
  assign alu_stall_o = (fifo_count != '0);

  wb_skid_fifo #(
    .WIDTH($bits(wb_payload_t)),
    .DEPTH(ALU_WB_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (alu_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      rr         <= 1'b0;
      mul_wait   <= '0;
      lsu_wait   <= '0;
      wb_valid_o <= 1'b0;
      wb_sid_o   <= '0;
      wb_rd_o    <= '0;
      wb_value_o <= '0;
      wb_src_o   <= '0;
    end else begin
      run      <= 1'b1;
      mul_wait <= next_wait(mul_valid_i, grant == GNT_MUL, mul_wait);
      lsu_wait <= next_wait(lsu_valid_i, grant == GNT_LSU, lsu_wait);
      if (grant == GNT_MUL)      rr <= 1'b1;
      else if (grant == GNT_LSU) rr <= 1'b0;
      // Payload holds its last value when nothing is granted.
      if (grant != GNT_NONE) begin
        wb_valid_o <= 1'b1;
        wb_sid_o   <= sel.sid;
        wb_rd_o    <= sel.rd;
        wb_value_o <= sel.value;
        wb_src_o   <= sel_src;
      end else begin
        wb_valid_o <= 1'b0;
      end
    end
  end

endmodule
